// File: rtl/step_pkg.sv
`default_nettype none
// ============================================================================
// Module   : step_pkg
// Purpose  : Shared state encoding and clamp limits for the step generator.
// Revision : 1.0  initial release
// ============================================================================
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } step_state_t;

    localparam int STEP_MIN_PERIOD = 2;
    localparam int STEP_MIN_HIGH   = 1;

endpackage
`default_nettype wire

// File: rtl/step_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : step_phase_timer
// Purpose  : Down-counter timing one phase; expire is high in its last cycle.
// Revision : 1.0  initial release
// ============================================================================
module step_phase_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // A phase of length L holds L-1..0, so expire marks the final cycle.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= len - c_one;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/step_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_generator
// Purpose  : Step/direction pulse train with direction setup, abort and an
//            optional symmetric linear ramp (enabled by STEP_RAMP_EN).
// Revision : 1.0  initial release
// ============================================================================
module step_pulse_generator
    import step_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int STEPS_W       = 32,
    parameter int DIR_SETUP_CYC = 16
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   high_cyc,
    input  logic [STEPS_W-1:0] steps,
    input  logic               dir_in,
    input  logic [CNT_W-1:0]   ramp_start,
    input  logic [CNT_W-1:0]   ramp_dec,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic [STEPS_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0]   c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_min_p     = CNT_W'(STEP_MIN_PERIOD);
    localparam logic [CNT_W-1:0]   c_min_h     = CNT_W'(STEP_MIN_HIGH);
    localparam logic [CNT_W-1:0]   c_setup_len = CNT_W'(DIR_SETUP_CYC);
    localparam logic [STEPS_W-1:0] c_step_one  = STEPS_W'(1);

    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        return (p < c_min_p) ? c_min_p : p;
    endfunction

    function automatic logic [CNT_W-1:0] eff_high(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] hh;
        hh = (h < c_min_h) ? c_min_h : h;
        return (hh > p - c_one) ? p - c_one : hh;
    endfunction

    step_state_t        r_state;
    logic               r_step, r_dir, r_busy, r_done, r_abort_pend;
    logic [STEPS_W-1:0] r_step_cnt, r_steps;
    logic [CNT_W-1:0]   r_high, r_cur_p;

    logic               w_accept, w_last, w_step_adv, w_load, w_expire;
    logic [CNT_W-1:0]   w_raw0, w_next_raw, w_len;
    logic [CNT_W-1:0]   w_p0, w_h0, w_p_cur, w_h_cur, w_p_nx, w_h_nx;

    assign w_accept   = (r_state == ST_IDLE) && start && !abort;
    assign w_last     = (r_step_cnt == r_steps);
    assign w_step_adv = (r_state == ST_LOW) && w_expire && !abort && !w_last;

    assign w_p0    = eff_period(w_raw0);
    assign w_h0    = eff_high(high_cyc, w_p0);
    assign w_p_cur = eff_period(r_cur_p);
    assign w_h_cur = eff_high(r_high, w_p_cur);
    assign w_p_nx  = eff_period(w_next_raw);
    assign w_h_nx  = eff_high(r_high, w_p_nx);

`ifdef STEP_RAMP_EN
    // r_cur_p walks from R down to the floor and back; r_pre/r_exc remember
    // where the floor was hit so the deceleration mirrors it exactly.
    logic [CNT_W-1:0]   r_floor, r_dec, r_pre;
    logic               r_sat;
    logic [STEPS_W-1:0] r_exc;
    logic [STEPS_W:0]   w_two_j, w_n;
    logic               w_sat_nx;
    logic [CNT_W-1:0]   w_pre_nx;
    logic [STEPS_W-1:0] w_exc_nx;

    assign w_raw0  = (ramp_start > period) ? ramp_start : period;
    assign w_two_j = {r_step_cnt, 1'b0};
    assign w_n     = {1'b0, r_steps};

    always_comb begin
        w_next_raw = r_cur_p;
        w_sat_nx   = r_sat;
        w_pre_nx   = r_pre;
        w_exc_nx   = r_exc;
        if (w_two_j < w_n) begin
            if (r_sat) begin
                w_exc_nx = r_exc + c_step_one;
            end else if (r_cur_p - r_floor <= r_dec) begin
                w_next_raw = r_floor;
                w_sat_nx   = 1'b1;
                w_pre_nx   = r_cur_p;
            end else begin
                w_next_raw = r_cur_p - r_dec;
            end
        end else if (w_two_j > w_n) begin
            if (r_sat) begin
                if (r_exc != '0) begin
                    w_exc_nx = r_exc - c_step_one;
                end else begin
                    w_next_raw = r_pre;
                    w_sat_nx   = 1'b0;
                end
            end else begin
                w_next_raw = r_cur_p + r_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_floor <= '0;
            r_dec   <= '0;
            r_pre   <= '0;
            r_sat   <= 1'b0;
            r_exc   <= '0;
        end else if (w_accept) begin
            r_floor <= period;
            r_dec   <= ramp_dec;
            r_pre   <= '0;
            r_sat   <= 1'b0;
            r_exc   <= '0;
        end else if (w_step_adv) begin
            r_pre   <= w_pre_nx;
            r_sat   <= w_sat_nx;
            r_exc   <= w_exc_nx;
        end
    end
`else
    logic w_unused_ramp;
    assign w_unused_ramp = ^{ramp_start, ramp_dec};
    assign w_raw0        = period;
    assign w_next_raw    = r_cur_p;
`endif

    always_comb begin
        w_load = 1'b0;
        w_len  = w_h_cur;
        case (r_state)
            ST_IDLE: begin
                w_load = w_accept && (steps != '0);
                w_len  = (DIR_SETUP_CYC == 0) ? w_h0 : c_setup_len;
            end
            ST_SETUP: begin
                w_load = w_expire && !abort;
                w_len  = w_h_cur;
            end
            ST_HIGH: begin
                w_load = w_expire && !(abort || r_abort_pend);
                w_len  = w_p_cur - w_h_cur;
            end
            ST_LOW: begin
                w_load = w_step_adv;
                w_len  = w_h_nx;
            end
            default: ;
        endcase
    end

    step_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .resetb (resetb),
        .load   (w_load),
        .len    (w_len),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= ST_IDLE;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_step_cnt   <= '0;
            r_steps      <= '0;
            r_high       <= '0;
            r_cur_p      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_steps      <= steps;
                        r_high       <= high_cyc;
                        r_cur_p      <= w_raw0;
                        r_dir        <= dir_in;
                        r_abort_pend <= 1'b0;
                        r_step_cnt   <= '0;
                        if (steps == '0) begin
                            r_done <= 1'b1;
                        end else if (DIR_SETUP_CYC == 0) begin
                            r_state    <= ST_HIGH;
                            r_step     <= 1'b1;
                            r_step_cnt <= c_step_one;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_expire) begin
                        r_state    <= ST_HIGH;
                        r_step     <= 1'b1;
                        r_step_cnt <= r_step_cnt + c_step_one;
                    end
                end
                ST_HIGH: begin
                    // An abort here is only remembered; the pulse always completes.
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_expire) begin
                        r_step <= 1'b0;
                        if (abort || r_abort_pend) begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (abort || (w_expire && w_last)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_step_adv) begin
                        r_state    <= ST_HIGH;
                        r_step     <= 1'b1;
                        r_step_cnt <= r_step_cnt + c_step_one;
                        r_cur_p    <= w_next_raw;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign busy     = r_busy;
    assign done     = r_done;
    assign step_cnt = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_pulse_generator
// Purpose  : Self-checking bench: vector table, corner sequences, random moves.
// Revision : 1.0  initial release
// ============================================================================
module tb_step_pulse_generator;

    localparam int D    = 16;
    localparam int MAXS = 16;

    logic        clk, resetb, start, abort, dir_in;
    logic [31:0] period, high_cyc, steps, ramp_start, ramp_dec;
    logic        step, dir, busy, done;
    logic [31:0] step_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] period, high_cyc, steps, ramp_start, ramp_dec;
        logic        dir;
        int          abort_at;   // 0: none, -1: random, >0: cycle offset
        int          exp_rise, exp_done, exp_cnt, exp_hlen;
    } vec_t;

    vec_t vecs[$];

    step_pulse_generator #(
        .CNT_W         (32),
        .STEPS_W       (32),
        .DIR_SETUP_CYC (D)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .start      (start),
        .abort      (abort),
        .period     (period),
        .high_cyc   (high_cyc),
        .steps      (steps),
        .dir_in     (dir_in),
        .ramp_start (ramp_start),
        .ramp_dec   (ramp_dec),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .step_cnt   (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int per, int hc, int st, bit dr, int rs, int dc, int ab,
                                int er, int ed, int ec, int eh);
        vec_t v;
        v.period = per; v.high_cyc = hc; v.steps = st; v.dir = dr;
        v.ramp_start = rs; v.ramp_dec = dc; v.abort_at = ab;
        v.exp_rise = er; v.exp_done = ed; v.exp_cnt = ec; v.exp_hlen = eh;
        return v;
    endfunction

    // Reference: per-step period/high from the closed-form rules, then the
    // whole expected waveform as a function of the cycle offset from start.
    task automatic run_move(input vec_t v, input int id,
                            output int m_rise, output int m_done,
                            output int m_cnt, output int m_hlen);
        int     n, acc, endc, ab, e_cnt;
        int     pk[MAXS], hk[MAXS], rk[MAXS];
        longint r;
        logic   e_step, e_busy, e_done, in_first;
`ifdef STEP_RAMP_EN
        longint x, d;
`endif
        n   = int'(v.steps);
        acc = 1 + D;
        for (int k = 0; k < n; k++) begin
            r = longint'(v.period);
`ifdef STEP_RAMP_EN
            if (longint'(v.ramp_start) > r) r = longint'(v.ramp_start);
            d = (k < n - 1 - k) ? k : n - 1 - k;
            x = r - longint'(v.ramp_dec) * d;
            if (x < longint'(v.period)) x = longint'(v.period);
            if (x > r) x = r;
            r = x;
`endif
            if (r < 2) r = 2;
            pk[k] = int'(r);
            hk[k] = (v.high_cyc == 0) ? 1 : int'(v.high_cyc);
            if (hk[k] > pk[k] - 1) hk[k] = pk[k] - 1;
            rk[k] = acc;
            acc  += pk[k];
        end
        endc = (n == 0) ? 1 : acc;
        ab   = v.abort_at;
        if (ab < 0) ab = (n > 0) ? int'($urandom_range(1, endc - 1)) : 0;
        if (ab > 0 && n > 0 && ab < endc) begin
            endc = ab + 1;
            for (int k = 0; k < n; k++)
                if (ab >= rk[k] && ab < rk[k] + hk[k]) endc = rk[k] + hk[k];
        end

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0;
        period = v.period; high_cyc = v.high_cyc; steps = v.steps;
        dir_in = v.dir; ramp_start = v.ramp_start; ramp_dec = v.ramp_dec;
        m_rise = -1; m_done = -1; m_cnt = -1; m_hlen = 0; in_first = 1'b0;
        for (int t = 1; t <= endc + 1; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (t == ab);
            if ((t == 2 || t == endc - 1) && t < endc) begin
                start      = 1'b1;
                period     = $urandom_range(1, 30);
                high_cyc   = $urandom_range(0, 30);
                steps      = $urandom_range(1, 9);
                dir_in     = ~v.dir;
                ramp_start = $urandom_range(0, 60);
                ramp_dec   = $urandom_range(0, 9);
            end
            @(negedge clk);
            e_step = 1'b0;
            e_cnt  = 0;
            for (int k = 0; k < n; k++) begin
                if (t >= rk[k] && t < rk[k] + hk[k] && t < endc) e_step = 1'b1;
                if (rk[k] <= t && rk[k] < endc) e_cnt++;
            end
            e_busy = (n > 0) && (t < endc);
            e_done = (t == endc);
            check($sformatf("v%0d t%0d step", id, t), longint'(step), longint'(e_step));
            check($sformatf("v%0d t%0d busy", id, t), longint'(busy), longint'(e_busy));
            check($sformatf("v%0d t%0d done", id, t), longint'(done), longint'(e_done));
            check($sformatf("v%0d t%0d step_cnt", id, t), longint'(step_cnt), longint'(e_cnt));
            check($sformatf("v%0d t%0d dir", id, t), longint'(dir), longint'(v.dir));
            if (step && m_rise < 0) begin
                m_rise = t; m_hlen = 1; in_first = 1'b1;
            end else if (in_first && step) begin
                m_hlen++;
            end else if (in_first) begin
                in_first = 1'b0;
            end
            if (done && m_done < 0) begin
                m_done = t; m_cnt = int'(step_cnt);
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin : main
        int   mr, md, mc, mh;
        vec_t last;
        resetb = 1'b0; start = 1'b0; abort = 1'b0; dir_in = 1'b1;
        period = 32'd7; high_cyc = 32'd3; steps = 32'd5; ramp_start = '0; ramp_dec = '0;

        vecs.push_back(mk(10,  3, 4, 1,  0,  0,  0,  17, 57, 4, 3));
        vecs.push_back(mk( 5,  2, 0, 0,  0,  0,  0,  -1,  1, 0, 0));
        vecs.push_back(mk( 1,  0, 3, 1,  0,  0,  0,  17, 23, 3, 1));
        vecs.push_back(mk(10, 20, 2, 0,  0,  0,  0,  17, 37, 2, 9));
        vecs.push_back(mk( 8,  5, 3, 1,  0,  0, 26,  17, 30, 2, 5));
        vecs.push_back(mk( 6,  2, 5, 0,  0,  0,  5,  -1,  6, 0, 0));
        vecs.push_back(mk( 6,  2, 5, 1,  0,  0, 20,  17, 21, 1, 2));
`ifdef STEP_RAMP_EN
        vecs.push_back(mk(10,  3, 6, 1, 30, 10,  0,  17, 137, 6, 3));
`else
        vecs.push_back(mk(10,  3, 2, 0, 30, 10,  0,  17, 37, 2, 3));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset step", longint'(step), 0);
        check("reset dir", longint'(dir), 0);
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check("reset step_cnt", longint'(step_cnt), 0);
        resetb = 1'b1;

        foreach (vecs[i]) begin
            run_move(vecs[i], i, mr, md, mc, mh);
            check($sformatf("v%0d first_rise", i), mr, vecs[i].exp_rise);
            check($sformatf("v%0d done_at", i), md, vecs[i].exp_done);
            check($sformatf("v%0d final_cnt", i), mc, vecs[i].exp_cnt);
            check($sformatf("v%0d first_high", i), mh, vecs[i].exp_hlen);
        end
        last = vecs[vecs.size() - 1];

        // start and abort together in IDLE: nothing may be accepted
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; steps = 32'd3; period = 32'd4; dir_in = ~last.dir;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            @(negedge clk);
            check($sformatf("sa t%0d busy", t), longint'(busy), 0);
            check($sformatf("sa t%0d done", t), longint'(done), 0);
            check($sformatf("sa t%0d step", t), longint'(step), 0);
            check($sformatf("sa t%0d step_cnt", t), longint'(step_cnt), longint'(last.exp_cnt));
            check($sformatf("sa t%0d dir", t), longint'(dir), longint'(last.dir));
        end

        // abort alone in IDLE is ignored
        @(posedge clk); #1;
        abort = 1'b1;
        for (int t = 1; t <= 2; t++) begin
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check($sformatf("ai t%0d done", t), longint'(done), 0);
            check($sformatf("ai t%0d busy", t), longint'(busy), 0);
        end

        // asynchronous reset in the middle of a high phase
        @(posedge clk); #1;
        start = 1'b1; period = 32'd10; high_cyc = 32'd5; steps = 32'd3;
        dir_in = 1'b1; ramp_start = '0; ramp_dec = '0;
        for (int t = 1; t <= 18; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("rst pre step", longint'(step), 1);
        check("rst pre busy", longint'(busy), 1);
        resetb = 1'b0;
        #1;
        check("rst step", longint'(step), 0);
        check("rst busy", longint'(busy), 0);
        check("rst step_cnt", longint'(step_cnt), 0);
        check("rst dir", longint'(dir), 0);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        check("rst post step", longint'(step), 0);
        check("rst post busy", longint'(busy), 0);

        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v = mk(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                   int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, 40)), int'($urandom_range(0, 15)),
                   ($urandom_range(0, 2) == 0) ? -1 : 0, 0, 0, 0, 0);
            run_move(v, 100 + i, mr, md, mc, mh);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_pulse_generator.md
# step_pulse_generator

Parametrised step/direction pulse generator for the stepper controller datapath. On a start request it emits a programmed number of step pulses with programmable period and high width, and drives a direction output with a guaranteed setup time before the first edge. It reports progress and completion, and supports abort without runt pulses. It supersedes the fixed free-running toggle generator and sits between the motion command logic and the driver pins.

## Interface
- `CNT_W`, 32: width of the period and high-width fields, and of the phase timer.
- `STEPS_W`, 32: width of the step-count field and the `step_cnt` output.
- `DIR_SETUP_CYC`, 16: clocks from direction update to the first step rising edge; 0 is allowed.
- `clk` input 1: clock.
- `resetb` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle start request; sampled only in IDLE.
- `abort` input 1: stop request; sampled in any busy state.
- `period` input CNT_W: clocks per step (target period).
- `high_cyc` input CNT_W: step high time in clocks.
- `steps` input STEPS_W: number of pulses to emit.
- `dir_in` input 1: requested direction.
- `ramp_start` input CNT_W: initial/final period for the ramp. Ignored unless `STEP_RAMP_EN` is defined.
- `ramp_dec` input CNT_W: period change per step. Ignored unless `STEP_RAMP_EN` is defined.
- `step` output 1: registered step pulse.
- `dir` output 1: registered direction.
- `busy` output 1: high from accept until completion.
- `done` output 1: single-cycle completion strobe (normal end or abort).
- `step_cnt` output STEPS_W: rising edges emitted in the current or last move.

## Operation
- **Reset values:** `step`=0, `dir`=0, `busy`=0, `done`=0, `step_cnt`=0, state IDLE.
- **States:** IDLE, SETUP, HIGH, LOW.
- **Accept:** `start`=1 in IDLE with `abort`=0.
  - Latch all inputs.
  - Set `step_cnt`=0 and `dir`=`dir_in`.
  - Go to SETUP. If `DIR_SETUP_CYC`=0, go directly to HIGH.
- **`start` and `abort` together in IDLE:** abort wins and `start` is ignored. `abort` alone in IDLE is ignored.
- **`start` while busy:** ignored. Latched values do not change mid-move.
- **`steps`=0:** no SETUP phase and no pulse. `done` pulses the cycle after accept, and `busy` stays 0.
- **Clamping of the effective period P:** P = max(P, 2).
- **Clamping of the effective high time H:** H = max(`high_cyc`, 1), then H = min(H, P−1).
  - H is recomputed against each step's P.
- **SETUP:** lasts `DIR_SETUP_CYC` cycles with `step`=0, then goes to HIGH.
- **HIGH:** `step`=1 for H cycles.
  - `step_cnt` increments on the cycle `step` rises.
  - Then goes to LOW.
- **LOW:** `step`=0 for P−H cycles.
  - Then goes to HIGH for the next step, or to IDLE after the last step.
  - The IDLE transition asserts `done` and drops `busy` in the same cycle.
- **Abort:**
  - In SETUP or LOW: go to IDLE next cycle with `done`=1.
  - In HIGH: finish the current high phase, then go to IDLE with `done`=1. No shortened pulse is produced.
  - `step_cnt` holds the number of pulses actually emitted.
- **`dir`:** changes only on accept and never while `busy`=1.
- **Arithmetic:** all counters are unsigned. P−H never underflows because of the clamp.

## Timing
- `start` is sampled at edge T. From T+1: `busy`=1 and `dir` is valid.
- Step k (1-based) rises at T+1+D+(k−1)·P, where D=`DIR_SETUP_CYC`. The high time lasts H cycles.
- For N steps: `done`=1 and `busy`=0 at T+1+D+N·P (constant-P case).
  - The earliest re-accept is that same cycle's edge.
- Abort latency:
  - From SETUP or LOW: 1 cycle.
  - From HIGH: the remaining high cycles plus 1.

## Configuration
- Macro: `STEP_RAMP_EN`.
- **Defined:** the period for step i (0-based) of N is  
  P_i = min(R, max(`period`, R − `ramp_dec`·min(i, N−1−i))), where R = max(`ramp_start`, `period`).
  - Gives symmetric linear acceleration and deceleration.
  - Computed incrementally (add/subtract `ramp_dec` per step) with saturation. No multiplier.
- **Undefined:** `ramp_start` and `ramp_dec` are ignored, every step uses P, and no ramp registers are synthesised.

## Structure
- Package `step_pkg`:
  - state enum (IDLE, SETUP, HIGH, LOW);
  - `STEP_MIN_PERIOD`=2;
  - `STEP_MIN_HIGH`=1.
- Sub-module `step_phase_timer`: a CNT_W down-counter loaded with the phase length, with a `load` input and an `expire` output. It is shared by SETUP, HIGH and LOW.

## Test plan
- `period`=10, `high_cyc`=3, `steps`=4, `DIR_SETUP_CYC`=16:
  - 4 pulses, 3 high / 7 low each;
  - first rise at T+17;
  - `done` at T+57;
  - `step_cnt`=4.
- `steps`=0 → `done` at T+1, no `step` edge, `busy` never 1.
- `high_cyc`=0 and `period`=1 → P=2, H=1 (alternating 1/1). `high_cyc`=20 with `period`=10 → H=9.
- `abort` on the second cycle of a HIGH with H=5 → `step` stays high for the full 5 cycles, `done` on the next cycle, `step_cnt`=2 when aborted during step 2.
- `start`+`abort` in the same IDLE cycle → no accept. `start` while busy → latched values unchanged. `resetb` low mid-HIGH → `step`=0 and `busy`=0 immediately.
- `STEP_RAMP_EN` with `period`=10, `ramp_start`=30, `ramp_dec`=10, `steps`=6 → step periods 30, 20, 10, 10, 20, 30.
